// File: rtl/cg_memory_pkg.sv
// Shared defaults for the behavioural word memory and its interface.
package cg_memory_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefWordNum   = 1024;

endpackage

// File: rtl/cg_memory_interface.sv
// Write/read handshake bundle for cg_memory_beh; clock and reset travel with the bundle.
interface cg_memory_interface #(
  parameter int unsigned DATA_WIDTH = cg_memory_pkg::DefDataWidth,
  parameter int unsigned ADDR_WIDTH = cg_memory_pkg::DefAddrWidth
) (
  input logic i_clk,
  input logic i_rstn
);

  logic                  wen;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  raddr_valid;
  logic                  raddr_ready;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  rdata_valid;
  logic                  rdata_ready;
  logic [DATA_WIDTH-1:0] rdata;

  modport mem (
    input  i_clk, i_rstn,
    input  wen, wdata_valid, waddr, wdata,
    input  raddr_valid, raddr, rdata_ready,
    output wdata_ready, raddr_ready, rdata_valid, rdata
  );

  modport master (
    input  i_clk, i_rstn,
    input  wdata_ready, raddr_ready, rdata_valid, rdata,
    output wen, wdata_valid, waddr, wdata,
    output raddr_valid, raddr, rdata_ready
  );

endinterface

// File: rtl/cg_memory_beh.sv
// Behavioural single-port-bundle word memory: non-stalling writes, one-entry registered read
// output with valid/ready back-pressure. Storage survives reset.
module cg_memory_beh import cg_memory_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned WORD_NUM   = DefWordNum
) (
  cg_memory_interface.mem if_mem
);

  localparam int unsigned IdxW = $clog2(WORD_NUM);

  // Zero at time 0 so simulation never reads X from unwritten words.
  logic [DATA_WIDTH-1:0] r_mem [WORD_NUM] = '{default: '0};

  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rdata_valid;

  logic [IdxW-1:0] w_widx;
  logic [IdxW-1:0] w_ridx;
  logic            w_wdata_ready;
  logic            w_raddr_ready;
  logic            w_wr_en;
  logic            w_rd_acc;

  // Word addresses wrap modulo WORD_NUM; upper bits are dropped.
  assign w_widx = IdxW'(if_mem.waddr);
  assign w_ridx = IdxW'(if_mem.raddr);

  assign w_wdata_ready = if_mem.i_rstn;
  assign w_raddr_ready = if_mem.i_rstn & (~r_rdata_valid | if_mem.rdata_ready);

  assign w_wr_en  = w_wdata_ready & if_mem.wen & if_mem.wdata_valid;
  assign w_rd_acc = w_raddr_ready & if_mem.raddr_valid;

  always_ff @(posedge if_mem.i_clk) begin
    if (w_wr_en) begin
      r_mem[w_widx] <= if_mem.wdata;
    end
  end

  // Read samples the pre-edge word, giving read-before-write on a same-index collision.
  always_ff @(posedge if_mem.i_clk) begin
    if (!if_mem.i_rstn) begin
      r_rdata_valid <= 1'b0;
      r_rdata       <= '0;
    end else if (w_rd_acc) begin
      r_rdata_valid <= 1'b1;
      r_rdata       <= r_mem[w_ridx];
    end else if (if_mem.rdata_ready) begin
      r_rdata_valid <= 1'b0;
    end
  end

  assign if_mem.wdata_ready = w_wdata_ready;
  assign if_mem.raddr_ready = w_raddr_ready;
  assign if_mem.rdata_valid = r_rdata_valid;
  assign if_mem.rdata       = r_rdata;

endmodule

// File: tb/tb_cg_memory_beh.sv
// Self-checking bench for cg_memory_beh: directed scenarios then randomized traffic
// against an array-based reference model.
module tb_cg_memory_beh;
  import cg_memory_pkg::*;

  localparam int unsigned Dw = DefDataWidth;
  localparam int unsigned Aw = DefAddrWidth;
  localparam int unsigned Wn = DefWordNum;

  logic clk;
  logic rstn;

  cg_memory_interface #(.DATA_WIDTH(Dw), .ADDR_WIDTH(Aw)) if_mem (
    .i_clk (clk),
    .i_rstn(rstn)
  );

  cg_memory_beh #(.DATA_WIDTH(Dw), .ADDR_WIDTH(Aw), .WORD_NUM(Wn)) u_dut (
    .if_mem(if_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  logic [Dw-1:0] ref_mem [Wn];
  logic          exp_valid;
  logic [Dw-1:0] exp_rdata;

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check handshake outputs, advance model, check read port.
  task automatic cyc(input logic we, input logic wv, input logic [Aw-1:0] wa,
                     input logic [Dw-1:0] wd, input logic rv, input logic [Aw-1:0] ra,
                     input logic rr);
    logic          acc;
    logic [Dw-1:0] old_word;
    if_mem.wen         = we;
    if_mem.wdata_valid = wv;
    if_mem.waddr       = wa;
    if_mem.wdata       = wd;
    if_mem.raddr_valid = rv;
    if_mem.raddr       = ra;
    if_mem.rdata_ready = rr;
    #1;
    check("wdata_ready", 64'(if_mem.wdata_ready), 64'(rstn));
    check("raddr_ready", 64'(if_mem.raddr_ready), 64'(rstn && (!exp_valid || rr)));
    @(posedge clk);
    if (!rstn) begin
      exp_valid = 1'b0;
      exp_rdata = '0;
    end else begin
      acc      = rv && (!exp_valid || rr);
      old_word = ref_mem[ra % Wn];
      if (we && wv) ref_mem[wa % Wn] = wd;
      if (acc) begin
        exp_valid = 1'b1;
        exp_rdata = old_word;
      end else if (rr) begin
        exp_valid = 1'b0;
      end
    end
    #1;
    check("rdata_valid", 64'(if_mem.rdata_valid), 64'(exp_valid));
    check("rdata", 64'(if_mem.rdata), 64'(exp_rdata));
  endtask

  task automatic idle(input logic rr);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, rr);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    exp_valid = 1'b0;
    exp_rdata = '0;
    for (int i = 0; i < int'(Wn); i++) ref_mem[i] = '0;

    // Reset with active-looking traffic: nothing may be written or accepted.
    rstn = 1'b0;
    cyc(1'b1, 1'b1, 32'h114, 32'hDEAD_BEEF, 1'b1, 32'h114, 1'b1);
    cyc(1'b1, 1'b1, 32'h115, 32'hDEAD_BEEF, 1'b1, 32'h115, 1'b0);
    check("reset_rvalid", 64'(if_mem.rdata_valid), 64'd0);
    check("reset_rdata", 64'(if_mem.rdata), 64'd0);
    rstn = 1'b1;
    idle(1'b1);

    // Unwritten word reads zero even though a write was attempted under reset.
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 32'h114, 1'b1);
    check("no_write_in_reset", 64'(if_mem.rdata), 64'd0);

    // Writes through wrapped addresses
    cyc(1'b1, 1'b1, 32'h514, 32'h114, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b1, 32'h515, 32'h214, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b1, 32'h516, 32'hAAAA_AAAA, 1'b0, '0, 1'b1);
    // wen without wdata_valid must not write
    cyc(1'b1, 1'b0, 32'h516, 32'h1234_5678, 1'b0, '0, 1'b1);

    // Read 0x514, then hold with rdata_ready low
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 32'h514, 1'b1);
    check("rd_514", 64'(if_mem.rdata), 64'h114);
    check("rd_514_valid", 64'(if_mem.rdata_valid), 64'd1);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 32'h515, 1'b0);
    check("hold_rready_blocked", 64'(if_mem.raddr_ready), 64'd0);
    idle(1'b0);
    check("hold_rdata", 64'(if_mem.rdata), 64'h114);

    // Drain and reload at the same edge; read-before-write on 0x516
    cyc(1'b1, 1'b1, 32'h516, 32'h314, 1'b1, 32'h516, 1'b1);
    check("rbw_old", 64'(if_mem.rdata), 64'hAAAA_AAAA);
    check("rbw_valid_stays", 64'(if_mem.rdata_valid), 64'd1);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 32'h516, 1'b1);
    check("rbw_new", 64'(if_mem.rdata), 64'h314);

    // Drain: valid clears, data kept
    idle(1'b1);
    check("drain_valid", 64'(if_mem.rdata_valid), 64'd0);
    check("drain_keep", 64'(if_mem.rdata), 64'h314);

    // Address wrap
    cyc(1'b1, 1'b1, 32'h114, 32'h5, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 32'h514, 1'b1);
    check("wrap", 64'(if_mem.rdata), 64'h5);

    // Reset while valid discards data, storage retained
    rstn = 1'b0;
    idle(1'b0);
    check("rst_discard_valid", 64'(if_mem.rdata_valid), 64'd0);
    check("rst_discard_data", 64'(if_mem.rdata), 64'd0);
    rstn = 1'b1;
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 32'h515, 1'b1);
    check("retained", 64'(if_mem.rdata), 64'h214);

    // Randomized traffic over a few colliding indices with random upper address bits
    for (int n = 0; n < 600; n++) begin
      logic [Aw-1:0] wa;
      logic [Aw-1:0] ra;
      wa   = ($urandom() & ~32'(Wn - 1)) | 32'($urandom_range(0, 7));
      ra   = ($urandom() & ~32'(Wn - 1)) | 32'($urandom_range(0, 7));
      rstn = ($urandom_range(0, 39) != 0);
      cyc(1'($urandom()), 1'($urandom()), wa, $urandom(), 1'($urandom()), ra,
          1'($urandom()));
    end
    rstn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cg_memory_beh.md
CG_MEMORY_BEH -- requirements
Module: cg_memory_beh

Interface
REQ-001 Parameter: DATA_WIDTH, 32, data word width in bits.
REQ-002 Parameter: ADDR_WIDTH, 32, address width in bits.
REQ-003 Parameter: WORD_NUM, 1024, number of storage words; power of two, at least 2.
REQ-004 The single port SHALL be if_mem of type cg_memory_interface #(DATA_WIDTH, ADDR_WIDTH), using a memory-side modport; the interface SHALL carry i_clk and i_rstn as its own ports.
REQ-005 One clock; reset is synchronous and active-low. The clock is i_clk and the reset is i_rstn; both are taken from if_mem.
REQ-006 i_clk  input  1  clock; all state updates on the rising edge.
REQ-007 i_rstn  input  1  synchronous active-low reset.
REQ-008 wen  input  1  write enable.
REQ-009 wdata_valid  input  1  write data valid.
REQ-010 wdata_ready  output  1  write can be accepted.
REQ-011 waddr  input  ADDR_WIDTH  write word address.
REQ-012 wdata  input  DATA_WIDTH  write data.
REQ-013 raddr_valid  input  1  read request valid.
REQ-014 raddr_ready  output  1  read request can be accepted.
REQ-015 raddr  input  ADDR_WIDTH  read word address.
REQ-016 rdata_valid  output  1  read data valid.
REQ-017 rdata_ready  input  1  consumer accepts read data.
REQ-018 rdata  output  DATA_WIDTH  read data.

Function
REQ-019 Addresses SHALL be word addresses; the storage index SHALL be addr[$clog2(WORD_NUM)-1:0], so higher bits are ignored and addresses wrap modulo WORD_NUM. For example, 0x514 maps to index 0x114.
REQ-020 wdata_ready SHALL be 1 whenever i_rstn is 1; writes never stall.
REQ-021 A write SHALL occur at a rising edge when i_rstn, wen, wdata_valid and wdata_ready are all 1: mem[idx(waddr)] <= wdata. No other condition SHALL modify storage.
REQ-022 The read path SHALL be a one-entry output register.
REQ-023 raddr_ready SHALL equal !rdata_valid || rdata_ready (combinational).
REQ-024 A read request SHALL be accepted at an edge where raddr_valid && raddr_ready.
REQ-025 On read acceptance, rdata SHALL load the value mem[idx(raddr)] held before that edge, and rdata_valid SHALL go to 1 after that same edge; latency is 1 cycle.
REQ-026 Once rdata_valid is 1, rdata and rdata_valid SHALL hold stable until an edge with rdata_ready=1.
REQ-027 At an edge with rdata_ready=1 and no new acceptance, rdata_valid SHALL clear to 0 and rdata SHALL keep its last value.
REQ-028 When data is drained and a new request is accepted at the same edge, the register SHALL reload and rdata_valid SHALL stay 1.
REQ-029 A simultaneous read and write to the same index at the same edge SHALL be read-before-write: rdata returns the old word, and a later read returns the new word.
REQ-030 Reads and writes to different indices at the same edge SHALL be independent.
REQ-031 Storage SHALL be zero-initialised at time 0 for simulation. The model is behavioural and need not be synthesisable storage.

Reset
REQ-032 When i_rstn=0 at a rising edge: rdata_valid <= 0 and rdata <= 0.
REQ-033 While i_rstn=0, wdata_ready and raddr_ready SHALL be 0, and no write or read acceptance SHALL occur.
REQ-034 Reset SHALL NOT clear storage contents.
REQ-035 A reset asserted while rdata_valid=1 SHALL discard the pending read data.

Structure
REQ-036 cg_memory_interface SHALL be a separate file declaring all signals above, with memory-side and master-side modports.
REQ-037 Package cg_memory_pkg SHALL hold the default DATA_WIDTH, ADDR_WIDTH and WORD_NUM constants.
REQ-038 cg_memory_beh SHALL contain the storage array, the write logic and the read output register directly, with no sub-modules.

Verification
REQ-039 Write 0x514<-0x114, 0x515<-0x214 and 0x516<-0xAAAAAAAA, each as a 1-cycle wen/wdata_valid pulse -> mem[0x114], mem[0x115] and mem[0x116] hold those values.
REQ-040 Read 0x514 with rdata_ready=1 for one cycle -> one edge later rdata=0x114 and rdata_valid=1; it holds while rdata_ready=0.
REQ-041 Same edge: read 0x516 and write 0x516<-0x314 -> rdata=0xAAAAAAAA; a following read of 0x516 -> rdata=0x314.
REQ-042 Hold rdata_ready=0 with rdata_valid=1 -> raddr_ready=0 and rdata stable; assert rdata_ready -> rdata_valid clears after one edge.
REQ-043 Write 0x114<-0x5 and then read 0x514 -> rdata=0x5 (address wrap).
REQ-044 Assert i_rstn=0 for one cycle while rdata_valid=1 -> rdata_valid=0 and rdata=0; a subsequent read of 0x515 -> 0x214 (contents retained).
